// File: rtl/spi_master_ctrl_if.sv
// Parallel request/response bus between system control logic and spi_master_ctrl.
// master modport = requester side, slave modport = the SPI controller itself.
interface spi_master_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic [DATA_WIDTH-1:0] tx_data;
  logic [1:0]            mode;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] rx_data;

  modport master (
    output start, tx_data, mode,
    input  busy, done, rx_data
  );

  modport slave (
    input  start, tx_data, mode,
    output busy, done, rx_data
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// Single-slave SPI master: one full-duplex DATA_WIDTH-bit transfer per accepted start, all four modes.
// Define SPI_LSB_FIRST_EN for LSB-first shifting in both directions; default is MSB-first.
module spi_master_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic              inclk,
  input  logic              reset,
  spi_master_ctrl_if.slave  bus,
  output logic              sclk,
  output logic              ss,
  output logic              mosi,
  input  logic              miso
);

  localparam int EDGE_W = $clog2(2 * DATA_WIDTH) + 1;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_WIDTH);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [EDGE_W-1:0]     edge_cnt_q, edge_cnt_d;
  logic                  cpha_q, cpha_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  sclk_q, sclk_d;
  logic                  ss_q, ss_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  sample_q, sample_d;

  logic                  div_last;
  logic [EDGE_W-1:0]     edge_next;
  logic                  edge_is_sample;

`ifdef SPI_LSB_FIRST_EN
  function automatic logic tx_first(input logic [DATA_WIDTH-1:0] w);
    return w[0];
  endfunction
  function automatic logic [DATA_WIDTH-1:0] tx_advance(input logic [DATA_WIDTH-1:0] w);
    return {1'b0, w[DATA_WIDTH-1:1]};
  endfunction
  function automatic logic [DATA_WIDTH-1:0] rx_insert(input logic [DATA_WIDTH-1:0] w, input logic b);
    return {b, w[DATA_WIDTH-1:1]};
  endfunction
`else
  function automatic logic tx_first(input logic [DATA_WIDTH-1:0] w);
    return w[DATA_WIDTH-1];
  endfunction
  function automatic logic [DATA_WIDTH-1:0] tx_advance(input logic [DATA_WIDTH-1:0] w);
    return {w[DATA_WIDTH-2:0], 1'b0};
  endfunction
  function automatic logic [DATA_WIDTH-1:0] rx_insert(input logic [DATA_WIDTH-1:0] w, input logic b);
    return {w[DATA_WIDTH-2:0], b};
  endfunction
`endif

  assign div_last  = (div_cnt_q == DIV_LAST);
  assign edge_next = edge_cnt_q + 1'b1;
  // CPHA=0 samples on odd edges, CPHA=1 on even edges.
  assign edge_is_sample = edge_next[0] ^ cpha_q;

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    edge_cnt_d = edge_cnt_q;
    cpha_d     = cpha_q;
    tx_shift_d = tx_shift_q;
    rx_data_d  = rx_data_q;
    sclk_d     = sclk_q;
    ss_d       = ss_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sample_d   = 1'b0;
    // miso is captured in the inclk cycle during which the sampling edge is on the pin.
    rx_shift_d = sample_q ? rx_insert(rx_shift_q, miso) : rx_shift_q;

    case (state_q)
      IDLE: begin
        sclk_d = bus.mode[1];
        ss_d   = 1'b1;
        mosi_d = 1'b0;
        if (bus.start && !busy_q) begin
          cpha_d     = bus.mode[0];
          ss_d       = 1'b0;
          busy_d     = 1'b1;
          div_cnt_d  = '0;
          edge_cnt_d = '0;
          rx_shift_d = '0;
          state_d    = SETUP;
          if (!bus.mode[0]) begin
            mosi_d     = tx_first(bus.tx_data);
            tx_shift_d = tx_advance(bus.tx_data);
          end else begin
            tx_shift_d = bus.tx_data;
          end
        end
      end

      SETUP, XFER: begin
        div_cnt_d = div_last ? '0 : div_cnt_q + 1'b1;
        if (div_last) begin
          sclk_d     = ~sclk_q;
          edge_cnt_d = edge_next;
          sample_d   = edge_is_sample;
          state_d    = (edge_next == LAST_EDGE) ? HOLD : XFER;
          if (!edge_is_sample && edge_next != LAST_EDGE) begin
            mosi_d     = tx_first(tx_shift_q);
            tx_shift_d = tx_advance(tx_shift_q);
          end
        end
      end

      HOLD: begin
        div_cnt_d = div_last ? '0 : div_cnt_q + 1'b1;
        if (div_last) begin
          state_d   = GAP;
          ss_d      = 1'b1;
          done_d    = 1'b1;
          mosi_d    = 1'b0;
          rx_data_d = rx_shift_d;
        end
      end

      GAP: begin
        // busy covers the minimum ss-high time before the next start can be taken.
        div_cnt_d = div_last ? '0 : div_cnt_q + 1'b1;
        if (div_last) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge inclk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      cpha_q     <= 1'b0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      sclk_q     <= 1'b0;
      ss_q       <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sample_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      cpha_q     <= cpha_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      sclk_q     <= sclk_d;
      ss_q       <= ss_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sample_q   <= sample_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;
  assign sclk        = sclk_q;
  assign ss          = ss_q;
  assign mosi        = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: cycle-level SPI slave/protocol monitor plus rx_data scoreboard.
// Expected wire bit order follows SPI_LSB_FIRST_EN when defined.
module tb_spi_master_ctrl;
  localparam int N = 8;
  localparam int D = 2;
  localparam int T = 1 + (2 * N + 1) * D;

  logic inclk = 1'b0;
  logic reset = 1'b1;
  logic sclk, ss, mosi, miso;

  spi_master_ctrl_if #(.DATA_WIDTH(N)) bus_if ();

  spi_master_ctrl #(.DATA_WIDTH(N), .CLK_DIV(D)) dut (
    .inclk (inclk),
    .reset (reset),
    .bus   (bus_if),
    .sclk  (sclk),
    .ss    (ss),
    .mosi  (mosi),
    .miso  (miso)
  );

  initial forever #5 inclk = ~inclk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int mon_rc;
  int s_edges  = 0;
  int f_done   = 0;
  bit s_act    = 1'b0;
  bit loopback = 1'b0;
  logic [1:0]   f_mode = 2'd0;
  logic [N-1:0] f_slave = '0;
  logic [N-1:0] s_tx, s_rx, exp_mosi, last_rx;
  logic         miso_drv = 1'b0;
  logic         prev_ss, prev_sclk, prev_busy;
  logic [N-1:0] sb_q[$];

  assign miso = loopback ? mosi : miso_drv;

  initial forever begin
    @(posedge inclk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave shifts MSB-first on the wire; converts a wire-order word into what the master assembles.
  function automatic logic [N-1:0] wire_order(input logic [N-1:0] w);
`ifdef SPI_LSB_FIRST_EN
    for (int i = 0; i < N; i++) wire_order[i] = w[N-1-i];
`else
    wire_order = w;
`endif
  endfunction

  // Slave model and protocol monitor, evaluated mid-cycle.
  initial begin
    prev_ss = 1'b1; prev_sclk = 1'b0; prev_busy = 1'b0;
    forever begin
      @(negedge inclk);
      if (reset) begin
        s_act = 1'b0; miso_drv = 1'b0;
        prev_ss = 1'b1; prev_sclk = sclk; prev_busy = 1'b0;
      end else begin
        mon_rc = cyc - acc_cyc;
        if (prev_ss && !ss) begin
          s_act = 1'b1; s_edges = 0; s_rx = '0; s_tx = f_slave;
          check("ss_fall_cycle", mon_rc, 1);
          check("sclk_at_ss_fall", sclk, f_mode[1]);
          if (!f_mode[0]) begin miso_drv = s_tx[N-1]; s_tx = s_tx << 1; end
        end else if (s_act && sclk !== prev_sclk) begin
          s_edges++;
          check("edge_cycle", mon_rc, 1 + s_edges * D);
          if (((s_edges % 2) == 1) == (f_mode[0] == 1'b0)) s_rx = {s_rx[N-2:0], mosi};
          else if (s_edges != 2 * N) begin miso_drv = s_tx[N-1]; s_tx = s_tx << 1; end
        end
        if (!prev_ss && ss && s_act) begin
          s_act = 1'b0;
          check("ss_rise_cycle", mon_rc, T);
        end
        if (bus_if.done) begin
          f_done++;
          check("done_cycle", mon_rc, T);
          check("ss_high_at_done", ss, 1'b1);
          check("mosi_zero_at_done", mosi, 1'b0);
          check("sb_has_entry", sb_q.size() > 0, 1'b1);
          if (sb_q.size() > 0) begin
            last_rx = sb_q.pop_front();
            check("rx_data", bus_if.rx_data, last_rx);
          end
        end
        if (prev_busy && !bus_if.busy) check("busy_fall_cycle", mon_rc, T + D);
        prev_ss = ss; prev_sclk = sclk; prev_busy = bus_if.busy;
      end
    end
  end

  task automatic run_frame(input logic [1:0] md, input logic [N-1:0] tx, input logic [N-1:0] sw,
                           input bit lb, input bit inject);
    int rc;
    f_mode = md; f_slave = sw; loopback = lb; f_done = 0;
    @(negedge inclk);
    bus_if.start = 1'b1; bus_if.tx_data = tx; bus_if.mode = md; acc_cyc = cyc;
    sb_q.push_back(lb ? tx : wire_order(sw));
    exp_mosi = wire_order(tx);
    @(negedge inclk);
    bus_if.start = 1'b0; bus_if.tx_data = ~tx;
    rc = 1;
    while (bus_if.busy && rc < 400) begin
      if (inject && (rc == 5 || rc == 20)) begin
        bus_if.start = 1'b1; bus_if.tx_data = 8'hFF; bus_if.mode = ~md;
      end else begin
        bus_if.start = 1'b0; bus_if.mode = md;
      end
      @(negedge inclk);
      rc++;
    end
    bus_if.start = 1'b0; bus_if.mode = md;
    check("busy_timeout", bus_if.busy, 1'b0);
    check("edge_count", s_edges, 2 * N);
    check("done_count", f_done, 1);
    check("slave_mosi", s_rx, exp_mosi);
    check("rx_hold", bus_if.rx_data, last_rx);
    check("sclk_idle", sclk, md[1]);
    check("ss_idle", ss, 1'b1);
    $display("frame mode=%0d tx=0x%02h rx=0x%02h slave_saw=0x%02h", md, tx, bus_if.rx_data, s_rx);
  endtask

  initial begin
    bus_if.start = 1'b0; bus_if.tx_data = '0; bus_if.mode = 2'd0;
    repeat (3) @(negedge inclk);
    check("rst_ss", ss, 1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_busy", bus_if.busy, 1'b0);
    check("rst_done", bus_if.done, 1'b0);
    check("rst_rx_data", bus_if.rx_data, 8'h00);
    reset = 1'b0;
    repeat (2) @(negedge inclk);

    run_frame(2'd0, 8'hA5, 8'h00, 1'b1, 1'b0);
    run_frame(2'd3, 8'h00, 8'h3C, 1'b0, 1'b0);
    run_frame(2'd1, 8'h81, 8'h00, 1'b1, 1'b0);
    run_frame(2'd2, 8'h81, 8'h00, 1'b1, 1'b0);
    run_frame(2'd0, 8'h3C, 8'hC3, 1'b0, 1'b1);
    run_frame(2'd1, 8'h96, 8'h69, 1'b0, 1'b0);

    // Abort a mode-0 frame with reset at cycle 10.
    f_mode = 2'd0; f_slave = 8'hC3; loopback = 1'b0; f_done = 0;
    @(negedge inclk);
    bus_if.start = 1'b1; bus_if.tx_data = 8'h5A; bus_if.mode = 2'd0; acc_cyc = cyc;
    sb_q.push_back(wire_order(8'hC3));
    @(negedge inclk);
    bus_if.start = 1'b0;
    check("abort_ss_low_before", ss, 1'b0);
    repeat (9) @(negedge inclk);
    reset = 1'b1;
    #1;
    check("abort_ss", ss, 1'b1);
    check("abort_sclk", sclk, 1'b0);
    check("abort_busy", bus_if.busy, 1'b0);
    check("abort_done", bus_if.done, 1'b0);
    check("abort_rx_data", bus_if.rx_data, 8'h00);
    repeat (T) @(negedge inclk);
    check("abort_no_done", f_done, 0);
    check("abort_ss_held", ss, 1'b1);
    $display("abort at cycle 10: ss=%0d busy=%0d rx=0x%02h", ss, bus_if.busy, bus_if.rx_data);
    sb_q.delete();
    reset = 1'b0;
    repeat (2) @(negedge inclk);

    run_frame(2'd0, 8'h01, 8'h80, 1'b0, 1'b0);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
